ram_access_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (8-bit address, 8-bit data, registered read, 1-cycle read latency) between two requesters.
- Each requester uses a valid/ready command handshake. Reads are returned on a per-requester response strobe.
- Sits between client logic and the RAM instance. It drives the RAM's address, write-enable, enable and write-data inputs, and samples its read-data output.

---
 rtl/ram_access_arbiter_pkg.sv | 28 ++
 rtl/ram_access_arbiter_chk.sv | 33 +++
 rtl/ram_access_arbiter_rr_arb2.sv | 45 ++++
 rtl/ram_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared definitions for the two-requester RAM access arbiter:
// default widths, requester identifiers and the round-robin pointer reset value.
package ram_access_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Requester identifier, also used as the round-robin pointer encoding
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // Pointer starts at REQ1 so that requester 0 wins the first contest
    localparam req_id_e LAST_GRANT_RST = REQ1;

    // The requester that is not 'id'; the preferred winner on contention
    function automatic req_id_e other_req(input req_id_e id);
        req_id_e res;
        if (id == REQ0) begin
            res = REQ1;
        end else begin
            res = REQ0;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_chk.sv
// Protocol checker for the RAM access arbiter; observes ports only.
module ram_access_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic req0_valid,
    input logic req0_ready,
    input logic req1_valid,
    input logic req1_ready,
    input logic ram_enable,
    input logic ram_write_en,
    input logic rsp0_valid,
    input logic rsp1_valid
);

    // At most one requester is accepted per cycle
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

    // Ready is only offered to a requester that is asking
    a_ready0_valid: assert property (@(posedge clk) disable iff (rst)
        req0_ready |-> req0_valid);
    a_ready1_valid: assert property (@(posedge clk) disable iff (rst)
        req1_ready |-> req1_valid);

    // A write strobe never appears without the RAM being enabled
    a_we_en: assert property (@(posedge clk) disable iff (rst)
        ram_write_en |-> ram_enable);

    // Only one read tag can retire per cycle
    a_one_rsp: assert property (@(posedge clk) disable iff (rst)
        !(rsp0_valid && rsp1_valid));

endmodule

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Combinational 2-way round-robin arbiter. The pointer register lives in the
// parent; this block only decides who wins in the current cycle.
module rr_arb2
    import ram_access_arbiter_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_e last_grant,
    output logic    grant0,
    output logic    grant1,
    output req_id_e winner
);

    // Grant decision: a lone requester always wins, contention goes to the
    // requester that did not win last time
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        winner = last_grant;
        case ({valid1, valid0})
            2'b01: begin
                grant0 = 1'b1;
                winner = REQ0;
            end
            2'b10: begin
                grant1 = 1'b1;
                winner = REQ1;
            end
            2'b11: begin
                winner = other_req(last_grant);
                if (winner == REQ0) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
                winner = last_grant;
            end
        endcase
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-requester front end for a single-port synchronous RAM with 1-cycle
// registered read. Commands are arbitrated round-robin, registered onto the
// RAM pins the following cycle, and read data is returned through a tagged
// pipeline on a per-requester response strobe three cycles after acceptance.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_en,
    output logic              ram_enable,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    req_id_e            last_grant_r;
    req_id_e            winner_s;
    logic               grant0_s;
    logic               grant1_s;
    logic               grant_any_s;

    logic               sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;

    // Read tag pipeline: stage 1 travels with the RAM command, stage 2 with
    // the cycle in which the RAM presents its read data
    logic               rd_pend1_r;
    req_id_e            rd_id1_r;
    logic               rd_pend2_r;
    req_id_e            rd_id2_r;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_r),
        .grant0     (grant0_s),
        .grant1     (grant1_s),
        .winner     (winner_s)
    );

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign grant_any_s = grant0_s | grant1_s;

    // Round-robin pointer: moves only when a command is actually accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= LAST_GRANT_RST;
        end else if (grant_any_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Command mux: pick the winning requester's fields
    always_comb begin
        sel_we_s    = req0_we;
        sel_addr_s  = req0_addr;
        sel_wdata_s = req0_wdata;
        if (winner_s == REQ1) begin
            sel_we_s    = req1_we;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_we_s    = req0_we;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

    // Stage 1: register the accepted command onto the RAM pins and tag reads;
    // on idle cycles the strobes drop while address and data hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_enable   <= 1'b0;
            ram_write_en <= 1'b0;
            ram_address  <= {ADDR_W{1'b0}};
            ram_data_in  <= {DATA_W{1'b0}};
            rd_pend1_r   <= 1'b0;
            rd_id1_r     <= REQ0;
        end else if (grant_any_s) begin
            ram_enable   <= 1'b1;
            ram_write_en <= sel_we_s;
            ram_address  <= sel_addr_s;
            ram_data_in  <= sel_wdata_s;
            rd_pend1_r   <= ~sel_we_s;
            rd_id1_r     <= winner_s;
        end else begin
            ram_enable   <= 1'b0;
            ram_write_en <= 1'b0;
            rd_pend1_r   <= 1'b0;
        end
    end

    // Stage 2: advance the read tag to line up with the RAM's read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend2_r <= 1'b0;
            rd_id2_r   <= REQ0;
        end else begin
            rd_pend2_r <= rd_pend1_r;
            rd_id2_r   <= rd_id1_r;
        end
    end

    // Response registers: capture RAM read data for the tagged requester and
    // pulse its strobe for one cycle; the data holds until its next response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= {DATA_W{1'b0}};
            rsp1_valid <= 1'b0;
            rsp1_rdata <= {DATA_W{1'b0}};
        end else begin
            if (rd_pend2_r && (rd_id2_r == REQ0)) begin
                rsp0_valid <= 1'b1;
                rsp0_rdata <= ram_data_out;
            end else begin
                rsp0_valid <= 1'b0;
            end
            if (rd_pend2_r && (rd_id2_r == REQ1)) begin
                rsp1_valid <= 1'b1;
                rsp1_rdata <= ram_data_out;
            end else begin
                rsp1_valid <= 1'b0;
            end
        end
    end

    ram_access_arbiter_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .ram_enable   (ram_enable),
        .ram_write_en (ram_write_en),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid)
    );

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a behavioural single-port RAM.
// The driver issues directed commands, checks the grant each cycle and pushes
// expected RAM commands and read responses; a monitor pops and compares.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_we = 1'b0;
    logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
    logic       req1_valid = 1'b0, req1_we = 1'b0;
    logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic [7:0] ram_address, ram_data_in;
    logic       ram_write_en, ram_enable;
    logic [7:0] ram_data_out = 8'h00;

    ram_access_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_address(ram_address), .ram_write_en(ram_write_en),
        .ram_enable(ram_enable), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read, not touched by rst
    logic [7:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_write_en) ram_mem[ram_address] <= ram_data_in;
            else              ram_data_out <= ram_mem[ram_address];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] data; int cyc; } cmd_t;
    typedef struct { logic [7:0] data; int cyc; } rsp_t;
    cmd_t cmd_q[$];
    rsp_t rsp_q0[$];
    rsp_t rsp_q1[$];
    logic [7:0] shadow [0:255];
    logic [7:0] last_addr   = 8'h00;
    logic [7:0] last_rdata0 = 8'h00;
    logic [7:0] last_rdata1 = 8'h00;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare RAM pins and response strobes against the scoreboard
    cmd_t mc;
    rsp_t mr;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_enable) begin
                if (cmd_q.size() == 0) begin
                    chk(1'b0, "ram_cmd_spurious", 32'(ram_address), 32'h0);
                end else begin
                    mc = cmd_q.pop_front();
                    chk(ram_write_en == mc.we, "ram_write_en", 32'(ram_write_en), 32'(mc.we));
                    chk(ram_address == mc.addr, "ram_address", 32'(ram_address), 32'(mc.addr));
                    if (mc.we) chk(ram_data_in == mc.data, "ram_data_in", 32'(ram_data_in), 32'(mc.data));
                    chk(cyc - mc.cyc == 1, "ram_cmd_latency", 32'(cyc - mc.cyc), 32'd1);
                    last_addr = mc.addr;
                end
            end else begin
                chk(ram_write_en == 1'b0, "idle_write_en", 32'(ram_write_en), 32'd0);
                chk(ram_address == last_addr, "idle_addr_hold", 32'(ram_address), 32'(last_addr));
            end
            if (rsp0_valid) begin
                if (rsp_q0.size() == 0) begin
                    chk(1'b0, "rsp0_spurious", 32'(rsp0_rdata), 32'h0);
                end else begin
                    mr = rsp_q0.pop_front();
                    chk(rsp0_rdata == mr.data, "rsp0_rdata", 32'(rsp0_rdata), 32'(mr.data));
                    chk(cyc - mr.cyc == 3, "rsp0_latency", 32'(cyc - mr.cyc), 32'd3);
                    last_rdata0 = mr.data;
                end
            end else begin
                chk(rsp0_rdata == last_rdata0, "rsp0_hold", 32'(rsp0_rdata), 32'(last_rdata0));
            end
            if (rsp1_valid) begin
                if (rsp_q1.size() == 0) begin
                    chk(1'b0, "rsp1_spurious", 32'(rsp1_rdata), 32'h0);
                end else begin
                    mr = rsp_q1.pop_front();
                    chk(rsp1_rdata == mr.data, "rsp1_rdata", 32'(rsp1_rdata), 32'(mr.data));
                    chk(cyc - mr.cyc == 3, "rsp1_latency", 32'(cyc - mr.cyc), 32'd3);
                    last_rdata1 = mr.data;
                end
            end else begin
                chk(rsp1_rdata == last_rdata1, "rsp1_hold", 32'(rsp1_rdata), 32'(last_rdata1));
            end
        end
    end

    // Drive one cycle of requests, check the grant, record expectations
    task automatic step(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                        input int exp_g, input string name);
        int   g;
        cmd_t c;
        rsp_t r;
        @(negedge clk);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        g = -1;
        if (req0_ready && req1_ready) g = 2;
        else if (req0_ready)          g = 0;
        else if (req1_ready)          g = 1;
        chk(g == exp_g, name, 32'(g), 32'(exp_g));
        if (g == 0 || g == 1) begin
            c.we   = (g == 1) ? w1 : w0;
            c.addr = (g == 1) ? a1 : a0;
            c.data = (g == 1) ? d1 : d0;
            c.cyc  = cyc;
            cmd_q.push_back(c);
            if (c.we) begin
                shadow[c.addr] = c.data;
            end else begin
                r.data = shadow[c.addr];
                r.cyc  = cyc;
                if (g == 0) rsp_q0.push_back(r);
                else        rsp_q1.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, -1, "idle_grant");
    endtask

    // Assert rst away from the clock edge, check async reset values, release
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cmd_q.delete();
        rsp_q0.delete();
        rsp_q1.delete();
        last_addr = 8'h00; last_rdata0 = 8'h00; last_rdata1 = 8'h00;
        #1;
        chk(ram_enable == 1'b0, "rst_ram_enable", 32'(ram_enable), 32'd0);
        chk(ram_write_en == 1'b0, "rst_ram_write_en", 32'(ram_write_en), 32'd0);
        chk(ram_address == 8'h00, "rst_ram_address", 32'(ram_address), 32'd0);
        chk(ram_data_in == 8'h00, "rst_ram_data_in", 32'(ram_data_in), 32'd0);
        chk({rsp0_valid, rsp1_valid} == 2'b00, "rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        chk(rsp0_rdata == 8'h00, "rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
        chk(rsp1_rdata == 8'h00, "rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            shadow[i]  = 8'h00;
        end
        do_reset();

        // Write then read back through requester 0
        step(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, "t1_wr_grant");
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, "t1_rd_grant");
        idle(3);

        // Preload, then sustained contention alternates starting with req0
        step(1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00, 0, "t2_pre0");
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22, 1, "t2_pre1");
        for (int i = 0; i < 6; i++)
            step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, i % 2, "t2_alt_grant");
        idle(3);

        // Read-after-write across requesters on consecutive cycles
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h5C, 1, "t3_wr_grant");
        step(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0, "t3_rd_grant");
        idle(3);

        // Lone req1 streams, then req0 wins the first contention
        for (int i = 0; i < 4; i++)
            step(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 1, "t4_solo1_grant");
        step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, "t4_contend0");
        step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, "t4_contend1");
        idle(3);

        // Reset right after a read is accepted: the read must vanish
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, "t5_rd_grant");
        do_reset();
        idle(5);

        // First contest after reset goes to req0
        step(1, 0, 8'h30, 8'h00, 1, 0, 8'h01, 8'h00, 0, "t6_first_contest");
        idle(5);

        chk(cmd_q.size() == 0, "cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        chk(rsp_q0.size() == 0, "rsp0_q_drained", 32'(rsp_q0.size()), 32'd0);
        chk(rsp_q1.size() == 0, "rsp1_q_drained", 32'(rsp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
